// File: rtl/c3lib_vecsync_arb_pkg.sv
// c3lib_vecsync_arb_pkg: shared FSM state type and ID-width helper for the vecsync arbiter
package c3lib_vecsync_arb_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, WAIT} vsarb_state_t;

    // Requester ID width, never narrower than one bit
    function automatic int calc_idw(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/c3lib_rr_arbiter.sv
// c3lib_rr_arbiter: combinational round-robin / fixed-priority request picker
//   req       : pending requests
//   pointer   : round-robin start index (ignored in fixed-priority mode)
//   grant     : one-hot winner
//   grant_idx : binary winner index
//   any_req   : at least one request pending
module c3lib_rr_arbiter
    import c3lib_vecsync_arb_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int ARB_MODE = 0,
    localparam int IDW     = calc_idw(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  pointer,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx,
    output logic            any_req
);

    int             base;
    logic [IDW-1:0] idx;

    // Fixed priority is a round-robin search that always starts at index 0
    assign base = (ARB_MODE == 0) ? int'(pointer) : 0;

    always_comb begin
        grant_idx = '0;
        any_req   = 1'b0;
        idx       = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = IDW'((base + k) % NREQ);
            if (!any_req && req[idx]) begin
                any_req   = 1'b1;
                grant_idx = idx;
            end
        end
        grant = any_req ? NREQ'(1) << grant_idx : '0;
    end

endmodule

// File: rtl/c3lib_vecsync_arb.sv
// c3lib_vecsync_arb: shares one vecsync handshake synchronizer among NREQ wr_clk requesters
//   wr_clk, wr_rst_n   : source clock, async active-low reset
//   req_vld/req_data   : per-requester request and packed payloads
//   req_ack            : one-cycle one-hot acceptance pulse
//   vs_data_in         : {grant_id, payload} to the synchronizer
//   vs_load_data_in    : synchronizer load strobe
//   vs_data_in_rdy2ld  : synchronizer ready-to-load
//   busy               : a transfer is in flight
//   timeout_err/err_clr: sticky watchdog flag and its clear
module c3lib_vecsync_arb
    import c3lib_vecsync_arb_pkg::*;
#(
    parameter int NREQ        = 4,
    parameter int DWIDTH      = 8,
    parameter int ARB_MODE    = 0,
    parameter int TIMEOUT_CYC = 1024,
    localparam int IDW        = calc_idw(NREQ)
) (
    input  logic                     wr_clk,
    input  logic                     wr_rst_n,
    input  logic [NREQ-1:0]          req_vld,
    input  logic [NREQ*DWIDTH-1:0]   req_data,
    output logic [NREQ-1:0]          req_ack,
    output logic [IDW+DWIDTH-1:0]    vs_data_in,
    output logic                     vs_load_data_in,
    input  logic                     vs_data_in_rdy2ld,
    output logic                     busy,
    output logic                     timeout_err,
    input  logic                     err_clr
);

    localparam int CW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

    vsarb_state_t          state, state_nxt;
    logic [IDW-1:0]        ptr, ptr_nxt, gnt_idx, cur_id;
    logic [NREQ-1:0]       gnt, ack_nxt;
    logic                  any_req, load_nxt, set_err;
    logic [IDW+DWIDTH-1:0] data_nxt;
    logic [CW-1:0]         wd_cnt, wd_cnt_nxt;

    c3lib_rr_arbiter #(
        .NREQ     (NREQ),
        .ARB_MODE (ARB_MODE)
    ) u_arb (
        .req       (req_vld),
        .pointer   (ptr),
        .grant     (gnt),
        .grant_idx (gnt_idx),
        .any_req   (any_req)
    );

    // The ID of the transfer in flight lives in the upper bits of vs_data_in
    assign cur_id = vs_data_in[DWIDTH +: IDW];

    always_comb begin
        state_nxt  = state;
        ack_nxt    = '0;
        load_nxt   = 1'b0;
        data_nxt   = vs_data_in;
        ptr_nxt    = ptr;
        wd_cnt_nxt = '0;
        set_err    = 1'b0;
        case (state)
            IDLE: begin
                if (vs_data_in_rdy2ld && any_req) begin
                    state_nxt = LOAD;
                    ack_nxt   = gnt;
                    load_nxt  = 1'b1;
                    data_nxt  = {gnt_idx, req_data[gnt_idx*DWIDTH +: DWIDTH]};
                end
            end
            LOAD: begin
                state_nxt = WAIT;
                ptr_nxt   = (ARB_MODE == 0) ? IDW'((int'(cur_id) + 1) % NREQ) : ptr;
            end
            WAIT: begin
                if (vs_data_in_rdy2ld) begin
                    state_nxt = IDLE;
                end else if (TIMEOUT_CYC != 0) begin
                    // Saturate so the flag fires once per stuck handshake and err_clr sticks
                    wd_cnt_nxt = (wd_cnt == CW'(TIMEOUT_CYC)) ? wd_cnt : wd_cnt + 1'b1;
                    set_err    = (wd_cnt == CW'(TIMEOUT_CYC - 1));
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            state           <= IDLE;
            ptr             <= '0;
            wd_cnt          <= '0;
            req_ack         <= '0;
            vs_data_in      <= '0;
            vs_load_data_in <= 1'b0;
            busy            <= 1'b0;
            timeout_err     <= 1'b0;
        end else begin
            state           <= state_nxt;
            ptr             <= ptr_nxt;
            wd_cnt          <= wd_cnt_nxt;
            req_ack         <= ack_nxt;
            vs_data_in      <= data_nxt;
            vs_load_data_in <= load_nxt;
            busy            <= (state_nxt != IDLE);
            timeout_err     <= set_err | (timeout_err & ~err_clr);
        end
    end

endmodule

// File: tb/tb_c3lib_vecsync_arb.sv
// tb_c3lib_vecsync_arb: scoreboard bench driving a round-robin and a fixed-priority instance
module tb_c3lib_vecsync_arb;

    localparam int N   = 4;
    localparam int DW  = 8;
    localparam int IDW = 2;
    localparam int OW  = IDW + DW;
    localparam int T   = 16;

    typedef logic [OW-1:0] exp_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    vld  [2];
    logic [N*DW-1:0] data [2];
    logic            rdy  [2];
    logic            clr  [2];
    logic [N-1:0]    ack  [2];
    logic [OW-1:0]   vdat [2];
    logic            load [2];
    logic            busy [2];
    logic            terr [2];

    int   n_chk = 0;
    int   n_fail = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t mon_e;
    int   m_ptr [2];
    int   m_wcnt[2];
    bit   m_free[2], m_skip[2], e_busy[2], e_err[2];
    bit   srdy[2], bp[2], hang[2], autoreq[2];
    bit   rt_rand;
    int   rt[2];
    int   rt_len;

    always #5 clk = ~clk;

    c3lib_vecsync_arb #(.NREQ(N), .DWIDTH(DW), .ARB_MODE(0), .TIMEOUT_CYC(T)) dut_rr (
        .wr_clk(clk), .wr_rst_n(rst_n), .req_vld(vld[0]), .req_data(data[0]), .req_ack(ack[0]),
        .vs_data_in(vdat[0]), .vs_load_data_in(load[0]), .vs_data_in_rdy2ld(rdy[0]),
        .busy(busy[0]), .timeout_err(terr[0]), .err_clr(clr[0]));

    c3lib_vecsync_arb #(.NREQ(N), .DWIDTH(DW), .ARB_MODE(1), .TIMEOUT_CYC(T)) dut_fp (
        .wr_clk(clk), .wr_rst_n(rst_n), .req_vld(vld[1]), .req_data(data[1]), .req_ack(ack[1]),
        .vs_data_in(vdat[1]), .vs_load_data_in(load[1]), .vs_data_in_rdy2ld(rdy[1]),
        .busy(busy[1]), .timeout_err(terr[1]), .err_clr(clr[1]));

    task automatic chk(input string nm, input int m, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d] at %0t: got %0h, expected %0h", nm, m, $time, act, exp);
        end
    endtask

    function automatic void push(input int m, input exp_t e);
        if (m == 0) q0.push_back(e);
        else q1.push_back(e);
    endfunction

    function automatic int qsize(input int m);
        return (m == 0) ? q0.size() : q1.size();
    endfunction

    function automatic exp_t pop(input int m);
        return (m == 0) ? q0.pop_front() : q1.pop_front();
    endfunction

    // Arbitration rule: scan upward from the start index, wrapping; instance 1 always starts at 0
    function automatic int pick(input int m);
        int base = (m == 0) ? m_ptr[0] : 0;
        for (int k = 0; k < N; k++)
            if (vld[m][(base + k) % N]) return (base + k) % N;
        return -1;
    endfunction

    // Reference model: free -> grant when ready and requested; one load cycle; wait for ready
    task automatic model_step(input int m);
        bit set = 1'b0;
        int g;
        if (m_free[m]) begin
            g = pick(m);
            if (rdy[m] && g >= 0) begin
                push(m, exp_t'({g[IDW-1:0], data[m][g*DW +: DW]}));
                m_free[m] = 1'b0;
                m_skip[m] = 1'b1;
                if (m == 0) m_ptr[0] = (g + 1) % N;
            end
        end else if (m_skip[m]) begin
            m_skip[m] = 1'b0;
        end else if (rdy[m]) begin
            m_free[m] = 1'b1;
            m_wcnt[m] = 0;
        end else begin
            m_wcnt[m]++;
            set = (m_wcnt[m] == T);
        end
        e_err[m]  = set | (e_err[m] & !clr[m]);
        e_busy[m] = !m_free[m];
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        for (int m = 0; m < 2; m++) begin
            if (!rst_n) begin
                m_free[m] = 1'b1;
                m_skip[m] = 1'b0;
                m_ptr[m]  = 0;
                m_wcnt[m] = 0;
                e_busy[m] = 1'b0;
                e_err[m]  = 1'b0;
                if (m == 0) q0.delete();
                else q1.delete();
            end else begin
                model_step(m);
            end
        end
    end

    initial forever begin
        @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            chk("load_vs_pending", m, load[m], qsize(m) > 0);
            if (qsize(m) > 0) begin
                mon_e = pop(m);
                if (load[m]) begin
                    chk("vs_data_in", m, vdat[m], mon_e);
                    chk("req_ack", m, ack[m], 1 << mon_e[OW-1:DW]);
                end
            end else begin
                chk("ack_idle", m, ack[m], 0);
            end
            chk("busy", m, busy[m], e_busy[m]);
            chk("timeout_err", m, terr[m], e_err[m]);
        end
    end

    // One clock step: synchronizer round-trip model and optional random requesters
    task automatic cyc();
        @(posedge clk);
        #1;
        for (int m = 0; m < 2; m++) begin
            if (load[m]) begin
                srdy[m] = 1'b0;
                rt[m]   = rt_rand ? int'($urandom_range(8, 2)) : rt_len;
            end else if (!srdy[m] && !hang[m]) begin
                if (rt[m] > 1) rt[m]--;
                else srdy[m] = 1'b1;
            end
            rdy[m] = srdy[m] & !bp[m];
            if (autoreq[m]) begin
                for (int i = 0; i < N; i++) begin
                    if (ack[m][i]) begin
                        vld[m][i] = ($urandom_range(1, 0) == 1);
                        data[m][i*DW +: DW] = DW'($urandom);
                    end else if (vld[m][i]) begin
                        if ($urandom_range(31, 0) == 0) vld[m][i] = 1'b0;
                    end else if ($urandom_range(3, 0) == 0) begin
                        vld[m][i] = 1'b1;
                        data[m][i*DW +: DW] = DW'($urandom);
                    end
                end
            end
        end
    endtask

    task automatic wait_idle(input int m);
        int n = 0;
        while (busy[m] && n < 200) begin
            cyc();
            n++;
        end
        chk("idle_reached", m, busy[m], 0);
    endtask

    task automatic wait_ack(input int m, output int idx);
        int n = 0;
        idx = -1;
        while (n < 100 && idx < 0) begin
            cyc();
            n++;
            for (int i = 0; i < N; i++)
                if (ack[m][i]) idx = i;
        end
    endtask

    initial begin
        int g;
        rst_n   = 1'b0;
        rt_rand = 1'b0;
        rt_len  = 6;
        for (int m = 0; m < 2; m++) begin
            vld[m]     = '0;
            data[m]    = '0;
            srdy[m]    = 1'b1;
            rdy[m]     = 1'b1;
            clr[m]     = 1'b0;
            bp[m]      = 1'b0;
            hang[m]    = 1'b0;
            autoreq[m] = 1'b0;
            rt[m]      = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int m = 0; m < 2; m++) begin
            chk("rst_vs_data_in", m, vdat[m], 0);
            chk("rst_load", m, load[m], 0);
            chk("rst_ack", m, ack[m], 0);
            chk("rst_busy", m, busy[m], 0);
            chk("rst_timeout", m, terr[m], 0);
        end
        rst_n = 1'b1;

        // Round-robin fairness with all requesters held
        vld[0]  = 4'hF;
        data[0] = 32'h44332211;
        for (int k = 0; k < 5; k++) begin
            wait_ack(0, g);
            chk("rr_order", 0, g, k % N);
        end
        vld[0] = '0;
        wait_idle(0);

        // Fixed priority: 1 beats 3 until 1 lets go
        vld[1]  = 4'b1010;
        data[1] = 32'h99887766;
        for (int k = 0; k < 3; k++) begin
            wait_ack(1, g);
            chk("fp_grant", 1, g, 1);
        end
        vld[1] = 4'b1000;
        wait_ack(1, g);
        chk("fp_after_drop", 1, g, 3);
        vld[1] = '0;
        wait_idle(1);

        // Single request, requester 2
        data[0]        = '0;
        data[0][23:16] = 8'hA5;
        vld[0]         = 4'b0100;
        wait_ack(0, g);
        chk("single_grant", 0, g, 2);
        chk("single_data", 0, vdat[0], 10'h2A5);
        chk("single_load", 0, load[0], 1);
        vld[0] = '0;
        cyc();
        chk("single_ack_pulse", 0, ack[0], 0);
        chk("single_load_pulse", 0, load[0], 0);
        chk("single_busy", 0, busy[0], 1);
        wait_idle(0);

        // Back-pressure: nothing moves while rdy2ld is low
        bp[0]  = 1'b1;
        rdy[0] = 1'b0;
        vld[0] = 4'b0001;
        repeat (8) begin
            cyc();
            chk("bp_no_ack", 0, ack[0], 0);
            chk("bp_no_load", 0, load[0], 0);
        end
        bp[0]  = 1'b0;
        rdy[0] = srdy[0];
        cyc();
        chk("bp_release_ack", 0, ack[0], 4'b0001);
        vld[0] = '0;
        wait_idle(0);

        // Watchdog: synchronizer never comes back
        hang[0] = 1'b1;
        vld[0]  = 4'b0010;
        wait_ack(0, g);
        chk("wd_grant", 0, g, 1);
        vld[0] = '0;
        repeat (T) cyc();
        chk("wd_before_limit", 0, terr[0], 0);
        cyc();
        chk("wd_at_limit", 0, terr[0], 1);
        repeat (5) cyc();
        chk("wd_sticky", 0, terr[0], 1);
        chk("wd_still_busy", 0, busy[0], 1);
        clr[0] = 1'b1;
        cyc();
        clr[0] = 1'b0;
        chk("wd_cleared", 0, terr[0], 0);
        hang[0] = 1'b0;
        wait_idle(0);
        chk("wd_stays_clear", 0, terr[0], 0);

        // Reset during LOAD drops the transfer and restarts the pointer
        vld[0] = 4'b0100;
        wait_ack(0, g);
        chk("prerst_grant", 0, g, 2);
        rst_n = 1'b0;
        #1;
        chk("midrst_ack", 0, ack[0], 0);
        chk("midrst_load", 0, load[0], 0);
        chk("midrst_busy", 0, busy[0], 0);
        chk("midrst_data", 0, vdat[0], 0);
        for (int m = 0; m < 2; m++) begin
            srdy[m] = 1'b1;
            rdy[m]  = 1'b1;
            rt[m]   = 0;
        end
        vld[0] = 4'b1001;
        repeat (2) cyc();
        rst_n = 1'b1;
        wait_ack(0, g);
        chk("postrst_grant", 0, g, 0);
        vld[0] = '0;
        wait_idle(0);

        // Randomized traffic on both instances
        rt_rand    = 1'b1;
        autoreq[0] = 1'b1;
        autoreq[1] = 1'b1;
        repeat (2000) cyc();
        autoreq[0] = 1'b0;
        autoreq[1] = 1'b0;
        vld[0]     = '0;
        vld[1]     = '0;
        wait_idle(0);
        wait_idle(1);
        repeat (2) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/c3lib_vecsync_arb.md
Name: c3lib_vecsync_arb

Overview:
Shares one c3lib_vecsync_handshake instance among NREQ requesters in the wr_clk domain.
- Arbitrates pending requests, round-robin or fixed priority.
- Tags the winning payload with its requester ID and drives the synchronizer load interface.
- Holds off further loads until the synchronizer reports ready again.
- Provides a watchdog that flags a handshake that never completes, e.g. when the read side is held in reset.

Parameters:
- NREQ, 4: number of requesters, 2..16.
- DWIDTH, 8: payload width per requester.
- ARB_MODE, 0: 0 = round-robin; 1 = fixed priority, lowest index wins.
- TIMEOUT_CYC, 1024: wr_clk cycles in WAIT before timeout_err is set; 0 disables the watchdog.
- IDW (localparam): max(1, clog2(NREQ)).

Ports:
- wr_clk, input, 1: source-domain clock.
- wr_rst_n, input, 1: reset, asynchronous, active-low.
- req_vld, input, NREQ: per-requester request. Held with req_data stable until req_ack.
- req_data, input, NREQ*DWIDTH: packed payloads. Requester i uses bits [i*DWIDTH +: DWIDTH].
- req_ack, output, NREQ: one-hot, one-cycle pulse; payload accepted.
- vs_data_in, output, IDW+DWIDTH: {grant_id, payload} to the synchronizer data_in.
- vs_load_data_in, output, 1: to the synchronizer load_data_in.
- vs_data_in_rdy2ld, input, 1: from the synchronizer data_in_rdy2ld.
- busy, output, 1: high whenever state != IDLE.
- timeout_err, output, 1: sticky watchdog flag.
- err_clr, input, 1: synchronous clear of timeout_err.

Behaviour:
- Reset state:
  - state = IDLE.
  - req_ack, vs_load_data_in, busy and timeout_err = 0.
  - vs_data_in = 0.
  - RR pointer = 0, meaning requester 0 has highest priority.
  - Watchdog counter = 0.
- All outputs are registered.
- IDLE: if vs_data_in_rdy2ld = 1 and |req_vld, then at the next edge:
  - Grant g is chosen by the arbiter.
  - vs_data_in <= {g, req_data[g]}.
  - vs_load_data_in <= 1.
  - req_ack[g] <= 1.
  - state <= LOAD.
  - If rdy2ld = 0 or no request is pending, remain in IDLE.
- LOAD: lasts exactly one cycle, during which vs_load_data_in = 1 and req_ack[g] = 1. At the next edge:
  - vs_load_data_in <= 0 and req_ack <= 0.
  - state <= WAIT.
  - In round-robin mode, pointer <= (g+1) mod NREQ.
- WAIT:
  - vs_load_data_in = 0.
  - The synchronizer's rdy2ld is guaranteed 0 on the first WAIT cycle.
  - When vs_data_in_rdy2ld = 1, state <= IDLE at the next edge.
  - vs_data_in holds its value until the next grant.
- Latency and throughput:
  - Request seen in IDLE → req_ack high 1 cycle later.
  - Back-to-back transfers are limited by the synchronizer round trip, plus 1 cycle for the IDLE re-arbitration decision.
- Round-robin arbitration: search starts at the pointer and wraps modulo NREQ. The first asserted req_vld wins, e.g. pointer = 3, NREQ = 4, req_vld = 4'b1001 → grant 3, then pointer = 0.
- Fixed-priority arbitration: the lowest asserted index wins. The pointer is unused.
- A requester that drops req_vld before req_ack loses its slot; no ack is issued to it.
- A requester keeping req_vld high after its ack is re-arbitrated as a new request.
- Watchdog:
  - Counter increments every WAIT cycle and clears on leaving WAIT.
  - When the counter reaches TIMEOUT_CYC, timeout_err <= 1.
  - The FSM keeps waiting; there is no abort.
  - err_clr clears timeout_err. If err_clr and a new timeout occur in the same cycle, set wins.
- wr_rst_n asserted mid-operation, in any state: immediate return to the reset state. Any in-flight transfer is dropped and no ack is issued. The synchronizer shares wr_rst_n, so both sides stay consistent.

Decomposition:
- Package c3lib_vecsync_arb_pkg holds:
  - typedef enum logic [1:0] {IDLE, LOAD, WAIT} vsarb_state_t.
  - Constant function for IDW.
- Sub-module c3lib_rr_arbiter (parameters NREQ, ARB_MODE):
  - Inputs: req, pointer.
  - Outputs: one-hot grant, binary grant index, any_req.
  - Combinational only; the pointer register stays in the parent.

Test Plan:
- Single request, NREQ=4, DWIDTH=8: req_vld=4'b0100, req_data[2]=8'hA5, rdy2ld=1 → req_ack=4'b0100 for exactly 1 cycle. vs_load_data_in high for exactly 1 cycle, with vs_data_in={2'd2,8'hA5}. busy until rdy2ld returns.
- Round-robin fairness: all 4 requesters held high, synchronizer model with 6-cycle round trip → grants are issued in order 0,1,2,3,0. Each is acked once per round, and there is never more than one load outstanding.
- Fixed priority, ARB_MODE=1, req_vld=4'b1010 held → requester 1 always granted. Requester 3 is granted only after requester 1 deasserts.
- Back-pressure: rdy2ld held 0 while req_vld=4'b0001 → no load and no ack. Release rdy2ld → ack after 1 cycle.
- Watchdog: TIMEOUT_CYC=16, rdy2ld never returns after a load → timeout_err=1 after 16 WAIT cycles, and it stays set. err_clr pulse → 0. Then rdy2ld=1 → IDLE.
- Reset mid-transfer: assert wr_rst_n low during LOAD → outputs reset immediately, with req_ack=0 and vs_load_data_in=0. After release, a pending request is granted normally and the pointer restarts at 0.
